// File: rtl/issue_inst_queue.sv
// -----------------------------------------------------------------------------
// issue_inst_queue
//
// Dual-write / dual-read circular instruction queue that sits between the
// 64-bit fetch return and the dual-issue decode stage.
//
// The fetch side pushes up to two {inst, pc} pairs per cycle. Valid slots are
// packed contiguously from the tail, with slot 1 written before slot 2. The
// decode side pops one or two entries from the head. The head and head+1
// entries are presented combinationally. full_o stalls the fetch side.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   flush             drop all contents; wins over same-cycle push and pop
//   push_inst1_i/2_i  instructions in the lower and upper fetch slots
//   push_pc1_i/2_i    PCs of the two fetch slots
//   push_valid1_i/2_i slot carries a real instruction
//   pop_i             decode consumes entries this cycle
//   pop_dual_i        consume two entries (one if only one is present)
//   head_inst1/2_o    instructions at head / head+1 (zero when absent)
//   head_pc1/2_o      PCs at head / head+1 (zero when absent)
//   head_ok1/2_o      at least one / two entries present
//   full_o            fewer than two free entries
//   count_o           occupancy
// -----------------------------------------------------------------------------
module issue_inst_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [31:0]       push_inst1_i,
  input  logic [31:0]       push_inst2_i,
  input  logic [31:0]       push_pc1_i,
  input  logic [31:0]       push_pc2_i,
  input  logic              push_valid1_i,
  input  logic              push_valid2_i,
  input  logic              pop_i,
  input  logic              pop_dual_i,
  output logic [31:0]       head_inst1_o,
  output logic [31:0]       head_inst2_o,
  output logic [31:0]       head_pc1_o,
  output logic [31:0]       head_pc2_o,
  output logic              head_ok1_o,
  output logic              head_ok2_o,
  output logic              full_o,
  output logic [ADDR_W:0]   count_o
);

  localparam logic [ADDR_W:0] FULL_THR = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] TWO      = (ADDR_W + 1)'(2);

  logic [31:0]       inst_mem [DEPTH];
  logic [31:0]       pc_mem   [DEPTH];

  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic [ADDR_W-1:0] head_p1;
  logic [ADDR_W-1:0] tail_p1;
  logic              push_ok;
  logic [1:0]        n_wr;
  logic [1:0]        n_pop;

  // Pointers are ADDR_W bits wide and DEPTH is a power of two, so the +1
  // addresses wrap modulo DEPTH on their own. This lets a pair straddle the
  // DEPTH-1 / 0 boundary.
  assign head_p1 = head_q + ADDR_W'(1);
  assign tail_p1 = tail_q + ADDR_W'(1);

  // The full check uses the registered count, so a push is dropped even when
  // a same-cycle pop would have made room.
  assign full_o  = (count_q >= FULL_THR);
  assign push_ok = !full_o;

  // NOTE: every signal driven here is given a default first, so no path through the block can infer a latch.
  always_comb begin
    n_wr  = 2'd0;
    n_pop = 2'd0;
    if (push_ok) begin
      n_wr = {1'b0, push_valid1_i} + {1'b0, push_valid2_i};
    end
    // A dual pop with only one entry present degrades to a single pop.
    if (pop_i && (count_q != '0)) begin
      n_pop = (pop_dual_i && (count_q >= TWO)) ? 2'd2 : 2'd1;
    end

    head_d  = head_q + ADDR_W'(n_pop);
    tail_d  = tail_q + ADDR_W'(n_wr);
    count_d = count_q + (ADDR_W + 1)'(n_wr) - (ADDR_W + 1)'(n_pop);

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments, so every register samples its pre-edge inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array has no reset. Its contents are masked by count, so clearing it would only cost logic.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok) begin
      if (push_valid1_i) begin
        inst_mem[tail_q] <= push_inst1_i;
        pc_mem[tail_q]   <= push_pc1_i;
        if (push_valid2_i) begin
          inst_mem[tail_p1] <= push_inst2_i;
          pc_mem[tail_p1]   <= push_pc2_i;
        end
      end else if (push_valid2_i) begin
        // A lone slot 2 is packed down to the tail, leaving no gap.
        inst_mem[tail_q] <= push_inst2_i;
        pc_mem[tail_q]   <= push_pc2_i;
      end
    end
  end

  assign head_ok1_o   = (count_q != '0);
  assign head_ok2_o   = (count_q >= TWO);
  assign head_inst1_o = head_ok1_o ? inst_mem[head_q]  : 32'd0;
  assign head_pc1_o   = head_ok1_o ? pc_mem[head_q]    : 32'd0;
  assign head_inst2_o = head_ok2_o ? inst_mem[head_p1] : 32'd0;
  assign head_pc2_o   = head_ok2_o ? pc_mem[head_p1]   : 32'd0;
  assign count_o      = count_q;

endmodule
